// File: rtl/si2c_slave_drive.sv
// si2c_slave_drive: I2C target byte engine with an auto-incrementing register pointer; define I2C_SLV_FILTER_EN to add a SCL/SDA glitch filter
module si2c_slave_drive #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int FILT_LEN = 4
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       i2c_scl_i,
  inout  wire        i2c_sda_io,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_MACK, S_WAIT} state_t;
  state_t state, state_d;
  logic [1:0] s1, s2, pin, pin_q;
  logic scl_rise, scl_fall, start, stop, last_rise, ack_end;
  logic [7:0] sh, byte_in;
  logic [2:0] bit_cnt;
  logic oe, rw, ptr_vld, acked;
`ifdef I2C_SLV_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [1:0][CW-1:0] fcnt;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      pin  <= 2'b11;
      fcnt <= '0;
    end else
      for (int i = 0; i < 2; i++)
        if (s2[i] == pin[i]) fcnt[i] <= '0;
        else if (fcnt[i] == CW'(FILT_LEN - 1)) begin
          pin[i]  <= s2[i];
          fcnt[i] <= '0;
        end else fcnt[i] <= fcnt[i] + 1'b1;
`else
  assign pin = s2;
`endif
  assign scl_rise   = pin[1] & ~pin_q[1];
  assign scl_fall   = ~pin[1] & pin_q[1];
  assign start      = pin[1] & pin_q[1] & pin_q[0] & ~pin[0];
  assign stop       = pin[1] & pin_q[1] & ~pin_q[0] & pin[0];
  assign byte_in    = {sh[6:0], pin[0]};
  assign i2c_sda_io = oe ? 1'b0 : 1'bz;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (start) state_d = S_ADDR;
    else if (stop) state_d = S_IDLE;
    else
      case (state)
        S_ADDR:  if (last_rise) state_d = byte_in[7:1] == DEV_ADDR ? S_AACK : S_WAIT;
        S_AACK:  if (ack_end) state_d = rw ? S_RD : S_WR;
        S_WR:    if (last_rise) state_d = S_WACK;
        S_WACK:  if (ack_end) state_d = S_WR;
        S_RD:    if (scl_fall && bit_cnt == 3'd7) state_d = S_MACK;
        S_MACK:  state_d = scl_rise && pin[0] ? S_WAIT : scl_fall && acked ? S_RD : S_MACK;
        default: ;
      endcase
  end
  always_comb begin
    last_rise = scl_rise && bit_cnt == 3'd7;
    ack_end   = scl_fall && oe;
    reg_rd_o  = (state == S_AACK && ack_end && rw) || (state == S_MACK && scl_fall && acked);
    busy_o    = state inside {S_AACK, S_WR, S_WACK, S_RD, S_MACK};
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      s1          <= 2'b11;
      s2          <= 2'b11;
      pin_q       <= 2'b11;
      sh          <= '0;
      bit_cnt     <= '0;
      oe          <= 1'b0;
      rw          <= 1'b0;
      ptr_vld     <= 1'b0;
      acked       <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wr_o    <= 1'b0;
    end else begin
      s1       <= {i2c_scl_i, i2c_sda_io};
      s2       <= s1;
      pin_q    <= pin;
      reg_wr_o <= 1'b0;
      if (reg_wr_o) reg_addr_o <= reg_addr_o + 8'd1;
      if (start || stop) begin
        oe      <= 1'b0;
        bit_cnt <= '0;
      end else if (reg_rd_o) begin
        sh      <= reg_rdata_i;
        oe      <= ~reg_rdata_i[7];
        bit_cnt <= '0;
        acked   <= 1'b0;
      end else
        case (state)
          S_ADDR, S_WR: if (scl_rise) begin
            sh      <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_rise) begin
              if (state == S_ADDR) rw <= byte_in[0];
              else if (!ptr_vld) begin
                reg_addr_o <= byte_in;
                ptr_vld    <= 1'b1;
              end else begin
                reg_wdata_o <= byte_in;
                reg_wr_o    <= 1'b1;
              end
            end
          end
          S_AACK, S_WACK: if (scl_fall) begin
            oe <= ~oe;
            if (state == S_AACK && oe) ptr_vld <= 1'b0;
          end
          S_RD: if (scl_fall) begin
            sh      <= {sh[6:0], 1'b0};
            oe      <= bit_cnt == 3'd7 ? 1'b0 : ~sh[6];
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_MACK: if (scl_rise) begin
            acked      <= ~pin[0];
            reg_addr_o <= reg_addr_o + 8'd1;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_si2c_slave_drive.sv
// tb_si2c_slave_drive: directed I2C master transactions against si2c_slave_drive
module tb_si2c_slave_drive;
  localparam int T = 6;
`ifdef I2C_SLV_FILTER_EN
  localparam logic [7:0] GLITCH_PTR = 8'h60;
`else
  localparam logic [7:0] GLITCH_PTR = 8'h30;
`endif
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_sda = 1'b1;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic reg_wr, reg_rd, busy;
  wire sda;
  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;
  logic [7:0] rmem [256];
  logic [7:0] wa[$], wd[$];
  int checks = 0, failures = 0, rd_cnt = 0, slave_low = 0, busy_hi = 0;
  always #5 clk = ~clk;
  assign reg_rdata = rmem[reg_addr];
  si2c_slave_drive dut (
    .clk_i(clk), .rst_n(rst_n), .i2c_scl_i(scl), .i2c_sda_io(sda),
    .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_wr_o(reg_wr),
    .reg_rd_o(reg_rd), .reg_rdata_i(reg_rdata), .busy_o(busy)
  );
  always @(negedge clk) begin
    if (reg_wr) begin
      wa.push_back(reg_addr);
      wd.push_back(reg_wdata);
    end
    if (reg_rd) rd_cnt++;
    if (sda === 1'b0 && m_sda) slave_low++;
    if (busy) busy_hi++;
  end
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic start_c();
    m_sda = 1'b1; wt(T); scl = 1'b1; wt(T); m_sda = 1'b0; wt(T); scl = 1'b0; wt(T);
  endtask
  task automatic stop_c();
    m_sda = 1'b0; wt(T); scl = 1'b1; wt(T); m_sda = 1'b1; wt(2 * T);
  endtask
  task automatic wbit(input logic b);
    m_sda = b; wt(T); scl = 1'b1; wt(2 * T); scl = 1'b0; wt(T);
  endtask
  task automatic rbit(output logic b);
    m_sda = 1'b1; wt(T); scl = 1'b1; wt(T); b = sda; wt(T); scl = 1'b0; wt(T);
  endtask
  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(ack);
  endtask
  task automatic rbyte(output logic [7:0] b, input logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      rbit(x);
      b[i] = x;
    end
    wbit(ack);
  endtask
  task automatic test_reset();
    wt(3);
    checks++; if ({reg_addr, reg_wdata, reg_wr, reg_rd, busy} !== 19'd0) begin failures++; $display("FAIL reset_in got=%h exp=0", {reg_addr, reg_wdata, reg_wr, reg_rd, busy}); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
    rst_n = 1'b1; wt(4);
    checks++; if ({reg_addr, reg_wdata, reg_wr, reg_rd, busy} !== 19'd0) begin failures++; $display("FAIL reset_out got=%h exp=0", {reg_addr, reg_wdata, reg_wr, reg_rd, busy}); end
  endtask
  task automatic test_write();
    logic [3:0] a;
    wa.delete(); wd.delete();
    start_c(); wbyte(8'hA0, a[0]);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
    wbyte(8'h10, a[1]); wbyte(8'h5A, a[2]); wbyte(8'hC3, a[3]); stop_c();
    checks++; if (a !== 4'b0000) begin failures++; $display("FAIL wr_acks got=%b exp=0000", a); end
    checks++; if (wa.size() != 2) begin failures++; $display("FAIL wr_count got=%0d exp=2", wa.size()); end
    else begin
      checks++; if ({wa[0], wd[0], wa[1], wd[1]} !== 32'h105A11C3) begin failures++; $display("FAIL wr_log got=%h exp=105a11c3", {wa[0], wd[0], wa[1], wd[1]}); end
    end
    checks++; if (reg_addr !== 8'h12) begin failures++; $display("FAIL wr_addr got=%h exp=12", reg_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_idle got=%b exp=0", busy); end
  endtask
  task automatic test_read();
    logic [2:0] a;
    logic [7:0] b0, b1;
    rmem[8'h20] = 8'h99; rmem[8'h21] = 8'h3C; rd_cnt = 0;
    start_c(); wbyte(8'hA0, a[0]); wbyte(8'h20, a[1]);
    start_c(); wbyte(8'hA1, a[2]);
    rbyte(b0, 1'b0); rbyte(b1, 1'b1);
    checks++; if (a !== 3'b000) begin failures++; $display("FAIL rd_acks got=%b exp=000", a); end
    checks++; if (b0 !== 8'h99) begin failures++; $display("FAIL rd_byte0 got=%h exp=99", b0); end
    checks++; if (b1 !== 8'h3C) begin failures++; $display("FAIL rd_byte1 got=%h exp=3c", b1); end
    checks++; if ({busy, sda} !== 2'b01) begin failures++; $display("FAIL rd_nack_wait busy,sda got=%b exp=01", {busy, sda}); end
    stop_c();
    checks++; if (rd_cnt != 2) begin failures++; $display("FAIL rd_strobes got=%0d exp=2", rd_cnt); end
    checks++; if (reg_addr !== 8'h22) begin failures++; $display("FAIL rd_addr got=%h exp=22", reg_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_idle got=%b exp=0", busy); end
  endtask
  task automatic test_mismatch();
    logic [1:0] a;
    wa.delete(); wd.delete(); rd_cnt = 0; slave_low = 0; busy_hi = 0;
    start_c(); wbyte(8'hA2, a[0]); wbyte(8'h55, a[1]); stop_c();
    checks++; if (a !== 2'b11) begin failures++; $display("FAIL mm_nacks got=%b exp=11", a); end
    checks++; if (slave_low != 0) begin failures++; $display("FAIL mm_sda_driven got=%0d exp=0", slave_low); end
    checks++; if (wa.size() + rd_cnt != 0) begin failures++; $display("FAIL mm_strobes got=%0d exp=0", wa.size() + rd_cnt); end
    checks++; if (busy_hi != 0) begin failures++; $display("FAIL mm_busy got=%0d exp=0", busy_hi); end
  endtask
  task automatic test_wrap();
    logic [3:0] a;
    wa.delete(); wd.delete();
    start_c(); wbyte(8'hA0, a[0]); wbyte(8'hFF, a[1]); wbyte(8'h11, a[2]); wbyte(8'h22, a[3]); stop_c();
    checks++; if (a !== 4'b0000) begin failures++; $display("FAIL wrap_acks got=%b exp=0000", a); end
    checks++; if (wa.size() != 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", wa.size()); end
    else begin
      checks++; if ({wa[0], wd[0], wa[1], wd[1]} !== 32'hFF110022) begin failures++; $display("FAIL wrap_log got=%h exp=ff110022", {wa[0], wd[0], wa[1], wd[1]}); end
    end
    checks++; if (reg_addr !== 8'h01) begin failures++; $display("FAIL wrap_addr got=%h exp=01", reg_addr); end
  endtask
  task automatic test_stop_mid_wr();
    logic [1:0] a;
    wa.delete(); wd.delete();
    start_c(); wbyte(8'hA0, a[0]); wbyte(8'h40, a[1]);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); stop_c();
    checks++; if (wa.size() != 0) begin failures++; $display("FAIL stop_mid_wr got=%0d exp=0", wa.size()); end
    checks++; if ({busy, reg_addr} !== 9'h040) begin failures++; $display("FAIL stop_mid_state busy,addr got=%h exp=040", {busy, reg_addr}); end
  endtask
  task automatic test_glitch();
    logic a;
    logic [7:0] p;
    p = 8'h60;
    start_c(); wbyte(8'hA0, a);
    m_sda = p[7]; wt(T); scl = 1'b1; wt(T); scl = 1'b0; wt(2); scl = 1'b1; wt(T); scl = 1'b0; wt(T);
    for (int i = 6; i >= 0; i--) wbit(p[i]);
    rbit(a); stop_c();
    checks++; if (reg_addr !== GLITCH_PTR) begin failures++; $display("FAIL glitch_ptr got=%h exp=%h", reg_addr, GLITCH_PTR); end
  endtask
  task automatic test_abort();
    logic [2:0] a;
    rmem[8'h30] = 8'h0F;
    start_c(); wbyte(8'hA0, a[0]); wbyte(8'h30, a[1]); start_c(); wbyte(8'hA1, a[2]); wt(T);
    checks++; if ({a, sda} !== 4'b0000) begin failures++; $display("FAIL abort_pre acks,sda got=%b exp=0000", {a, sda}); end
    rst_n = 1'b0; #1;
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL abort_sda got=%b exp=1", sda); end
    checks++; if ({reg_addr, reg_wdata, reg_wr, reg_rd, busy} !== 19'd0) begin failures++; $display("FAIL abort_outs got=%h exp=0", {reg_addr, reg_wdata, reg_wr, reg_rd, busy}); end
    m_sda = 1'b1; scl = 1'b1; wt(4); rst_n = 1'b1; wt(4);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_stop_mid_wr();
    test_glitch();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #20ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
